envelope_tracker: RTL and testbench
===================================

# envelope_tracker

Measures the amplitude envelope of the post-dynamics sample stream: per-window peak absolute value, decay level in eighths relative to the note's opening peak, and a silence flag. Sits downstream of the dynamics stage on the same sample/new_sample_ready strobe. Lets the design and the bench confirm that the applied decay steps actually appear at the output, and lets the note sequencer detect when a note has died out.

## Interface
- WINDOW_LOG2, 6: window length is 2^WINDOW_LOG2 accepted samples; legal range 1..10.
- SILENCE_THRESH, 16: a window whose peak is below this value is quiet.
- SILENT_WINDOWS, 4: number of consecutive quiet windows that asserts `silent`; legal range 1..15.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sample  input  16  signed two's-complement sample (the final_sample of the dynamics stage).
- new_sample_ready  input  1  one-cycle strobe; `sample` is valid this cycle; may be high on consecutive cycles.
- note_start  input  1  one-cycle pulse marking the beginning of a new note.
- peak  output  16  peak absolute value of the last completed window.
- level  output  4  decay level 0..8 (8 = full reference amplitude).
- level_valid  output  1  one-cycle pulse when peak/level update.
- silent  output  1  the note has decayed to silence.

## Operation
- States: IDLE (no note yet), REF (first window of a note), TRACK (later windows).
- IDLE: strobes are ignored; outputs hold their values. note_start -> REF.
- note_start in any state: clear the window counter and running max, enter REF. If new_sample_ready is in the same cycle, that sample is counted as sample 1 of the new window. The sample accepted that cycle must not be folded into the old window.
- Absolute value: |sample|, with -32768 saturating to 32767. The result is 15 bits, zero-extended to 16.
- Each accepted sample updates running_max = max(running_max, |sample|) and increments the window counter.
- Window end: on the 2^WINDOW_LOG2-th accepted sample:
  - peak <= max(running_max, |sample|).
  - Restart running_max at 0 and the counter at 0.
- REF window end: ref_peak <= that window's peak; level for this window = 8; go to TRACK.
- TRACK window end: level = number of k in 1..8 with 8*peak >= k*ref_peak, computed at 19-bit width with no overflow.
  - This gives floor(8*peak/ref_peak), clamped to 8.
  - If ref_peak == 0, level = 0.
- Silence tracking at every window end in REF/TRACK:
  - peak < SILENCE_THRESH: increment quiet_cnt, saturating at SILENT_WINDOWS.
  - Otherwise: clear quiet_cnt.
  - silent = (quiet_cnt == SILENT_WINDOWS).
  - note_start clears quiet_cnt but does not change `silent` until the next window end.
- Partial windows are discarded on note_start and never reported.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: peak = 0, level = 0, level_valid = 0, silent = 1.
  - Internal: ref_peak = 0, quiet_cnt = 0, counter = 0, running_max = 0.
- Latency:
  - Window-ending strobe in cycle t: peak is registered at the end of t.
  - level, level_valid and silent are registered at the end of t+1, so level_valid is high during cycle t+2 for exactly one cycle.
- Back-to-back strobes at full clock rate are supported with no stalls.
- With WINDOW_LOG2 = 1, consecutive level_valid pulses may be 2 cycles apart.
- Reset mid-window: all state is discarded; no level_valid is produced.
- A pending level/level_valid stage still completes if note_start arrives in cycle t+1.

## Configuration
- ENV_MONOTONIC_EN defined:
  - Within a note, a TRACK-window level is clamped to min(computed, previous level).
  - The first TRACK window is clamped against the REF level of 8.
  - The held level resets to 8 at each REF window.
- ENV_MONOTONIC_EN undefined: the raw computed level is reported.
- peak is always raw in both builds.

## Test plan
- Reset, then strobes with sample = 1000 and no note_start -> outputs stay peak = 0, level = 0, level_valid = 0, silent = 1.
- WINDOW_LOG2 = 2, note_start, then 4 strobes of ±8000 -> level_valid 2 cycles after the 4th strobe with peak = 8000, level = 8.
- Continue with a 4-sample window of 4000, then one of 1000 -> level = 4, then level = 1. Then send windows of 0: after 4 such windows silent = 1; a subsequent window of 100 clears silent.
- Sample = -32768 in the REF window -> peak = 32767. A later window peaking at 32767 gives level = 8.
- note_start coincident with the 3rd strobe of a window, sample = 500 -> the old window is never reported. The new window (500 plus 3 more) reports after 3 further strobes as the REF window with level = 8.
- With ENV_MONOTONIC_EN defined: REF = 8000, then windows of 2000 and 6000 -> levels 2, 2. Without the macro -> levels 2, 6.

Source files
------------

// File: rtl/envelope_tracker.sv
// rtl/envelope_tracker.sv - per-window peak, decay level in eighths and silence flag
// Optional ENV_MONOTONIC_EN: clamp each TRACK level to the previous level of the note.
module envelope_tracker #(
  parameter int WINDOW_LOG2    = 6,
  parameter int SILENCE_THRESH = 16,
  parameter int SILENT_WINDOWS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] sample,
  input  logic               new_sample_ready,
  input  logic               note_start,
  output logic        [15:0] peak,
  output logic        [3:0]  level,
  output logic               level_valid,
  output logic               silent
);

  typedef enum logic [1:0] {IDLE, REF, TRACK} state_t;

  localparam logic [15:0] THRESH = 16'(SILENCE_THRESH);
  localparam logic [3:0]  QUIET_MAX = 4'(SILENT_WINDOWS);

  state_t                 state;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [14:0]            running_max;
  logic [15:0]            ref_peak;
  logic [3:0]             quiet_cnt;
  logic                   pend;
  logic                   pend_ref;

  logic [15:0] neg_sample;
  logic [14:0] abs_sample;
  logic [14:0] win_max;
  logic        win_end;
  logic [18:0] peak_x8;
  logic [18:0] ref_mult;
  logic [3:0]  level_calc;
  logic [3:0]  level_next;

`ifdef ENV_MONOTONIC_EN
  logic [3:0] held_level;
`endif

  // -32768 has no positive counterpart, so it saturates to 32767.
  always_comb begin
    neg_sample = -sample;
    if (sample == 16'sh8000)
      abs_sample = 15'h7fff;
    else if (sample[15])
      abs_sample = neg_sample[14:0];
    else
      abs_sample = sample[14:0];
    win_max = (abs_sample > running_max) ? abs_sample : running_max;
    win_end = new_sample_ready && !note_start && (state != IDLE) && (win_cnt == '1);
  end

  // Count k in 1..8 with 8*peak >= k*ref_peak; 19 bits holds 8*32767 without overflow.
  always_comb begin
    peak_x8    = {peak, 3'b000};
    ref_mult   = 19'd0;
    level_calc = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      ref_mult = ref_mult + {3'b000, ref_peak};
      if (peak_x8 >= ref_mult)
        level_calc = level_calc + 4'd1;
    end
    if (ref_peak == 16'd0)
      level_calc = 4'd0;
`ifdef ENV_MONOTONIC_EN
    level_next = (level_calc < held_level) ? level_calc : held_level;
`else
    level_next = level_calc;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      win_cnt     <= '0;
      running_max <= 15'd0;
      peak        <= 16'd0;
      ref_peak    <= 16'd0;
      quiet_cnt   <= 4'd0;
      pend        <= 1'b0;
      pend_ref    <= 1'b0;
      level       <= 4'd0;
      level_valid <= 1'b0;
      silent      <= 1'b1;
`ifdef ENV_MONOTONIC_EN
      held_level  <= 4'd8;
`endif
    end else begin
      // Second stage: level/silent follow the peak registered one cycle earlier.
      pend        <= win_end;
      pend_ref    <= win_end && (state == REF);
      level_valid <= pend;
      if (pend) begin
        level  <= pend_ref ? 4'd8 : level_next;
        silent <= (quiet_cnt == QUIET_MAX);
`ifdef ENV_MONOTONIC_EN
        held_level <= pend_ref ? 4'd8 : level_next;
`endif
      end

      if (note_start) begin
        state     <= REF;
        quiet_cnt <= 4'd0;
        if (new_sample_ready) begin
          win_cnt     <= WINDOW_LOG2'(1);
          running_max <= abs_sample;
        end else begin
          win_cnt     <= '0;
          running_max <= 15'd0;
        end
      end else if (state != IDLE && new_sample_ready) begin
        if (win_end) begin
          win_cnt     <= '0;
          running_max <= 15'd0;
          peak        <= {1'b0, win_max};
          if (state == REF) begin
            ref_peak <= {1'b0, win_max};
            state    <= TRACK;
          end
          if ({1'b0, win_max} < THRESH)
            quiet_cnt <= (quiet_cnt == QUIET_MAX) ? quiet_cnt : quiet_cnt + 4'd1;
          else
            quiet_cnt <= 4'd0;
        end else begin
          win_cnt     <= win_cnt + 1'b1;
          running_max <= win_max;
        end
      end
    end
  end

endmodule

// File: tb/tb_envelope_tracker.sv
// tb/tb_envelope_tracker.sv - directed self-checking bench for envelope_tracker (WINDOW_LOG2 = 2)
module tb_envelope_tracker;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] sample;
  logic               new_sample_ready;
  logic               note_start;
  logic        [15:0] peak;
  logic        [3:0]  level;
  logic               level_valid;
  logic               silent;

  int checks = 0;
  int errors = 0;
  int lv_count = 0;
  int lv_base;

  envelope_tracker #(
    .WINDOW_LOG2(2),
    .SILENCE_THRESH(16),
    .SILENT_WINDOWS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample(sample),
    .new_sample_ready(new_sample_ready),
    .note_start(note_start),
    .peak(peak),
    .level(level),
    .level_valid(level_valid),
    .silent(silent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (level_valid) lv_count++;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic signed [15:0] v);
    sample = v;
    new_sample_ready = 1'b1;
    @(posedge clk); #1;
    new_sample_ready = 1'b0;
  endtask

  task automatic note_pulse();
    note_start = 1'b1;
    @(posedge clk); #1;
    note_start = 1'b0;
  endtask

  // Four back-to-back strobes; result expected during the second cycle after the last one.
  task automatic run_window(input string tag,
                            input logic signed [15:0] s0, s1, s2, s3,
                            input int ep, input int el, input int es,
                            input bit ns_first, input bit ns_t1);
    logic signed [15:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < 4; i++) begin
      sample = s[i];
      new_sample_ready = 1'b1;
      note_start = (i == 0) && ns_first;
      @(posedge clk); #1;
    end
    new_sample_ready = 1'b0;
    note_start = ns_t1;
    check({tag, "_lv_t1"}, 32'(level_valid), 0);
    @(posedge clk); #1;
    note_start = 1'b0;
    check({tag, "_lv"}, 32'(level_valid), 1);
    check({tag, "_peak"}, 32'(peak), ep);
    check({tag, "_level"}, 32'(level), el);
    check({tag, "_silent"}, 32'(silent), es);
    @(posedge clk); #1;
    check({tag, "_lv_off"}, 32'(level_valid), 0);
  endtask

  initial begin
    reset = 1'b1;
    sample = 16'sd0;
    new_sample_ready = 1'b0;
    note_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_peak", 32'(peak), 0);
    check("rst_level", 32'(level), 0);
    check("rst_lv", 32'(level_valid), 0);
    check("rst_silent", 32'(silent), 1);

    for (int i = 0; i < 5; i++) strobe(16'sd1000);
    repeat (3) @(posedge clk);
    #1;
    check("idle_peak", 32'(peak), 0);
    check("idle_level", 32'(level), 0);
    check("idle_silent", 32'(silent), 1);
    check("idle_lv_count", lv_count, 0);

    note_pulse();
    run_window("ref8000", 16'sd8000, -16'sd8000, 16'sd8000, -16'sd8000, 8000, 8, 0, 0, 0);
    run_window("w4000", 16'sd4000, 16'sd4000, -16'sd4000, 16'sd4000, 4000, 4, 0, 0, 0);
    run_window("w1000", 16'sd1000, -16'sd1000, 16'sd1000, 16'sd1000, 1000, 1, 0, 0, 0);
    run_window("zero1", 16'sd0, 16'sd0, 16'sd0, 16'sd0, 0, 0, 0, 0, 0);
    run_window("zero2", 16'sd0, 16'sd0, 16'sd0, 16'sd0, 0, 0, 0, 0, 0);
    run_window("zero3", 16'sd0, 16'sd0, 16'sd0, 16'sd0, 0, 0, 0, 0, 0);
    run_window("zero4", 16'sd0, 16'sd0, 16'sd0, 16'sd0, 0, 0, 1, 0, 0);
    run_window("w100", 16'sd100, -16'sd50, 16'sd0, 16'sd20, 100, 0, 0, 0, 0);

    note_pulse();
    run_window("ref_min", 16'sd5, -16'sd32768, 16'sd5, 16'sd5, 32767, 8, 0, 0, 0);
    run_window("w_max", 16'sd0, 16'sd32767, 16'sd0, 16'sd0, 32767, 8, 0, 0, 0);

    note_pulse();
    lv_base = lv_count;
    strobe(16'sd1000);
    strobe(16'sd1000);
    run_window("part_ref", 16'sd500, 16'sd200, 16'sd200, 16'sd200, 500, 8, 0, 1, 0);
    check("part_lv_count", lv_count - lv_base, 1);
    run_window("part_w250", 16'sd250, 16'sd0, 16'sd0, 16'sd0, 250, 4, 0, 0, 0);

    note_pulse();
    run_window("mono_ref", 16'sd8000, 16'sd0, 16'sd0, 16'sd0, 8000, 8, 0, 0, 0);
    run_window("mono_2000", 16'sd2000, 16'sd0, 16'sd0, 16'sd0, 2000, 2, 0, 0, 0);
`ifdef ENV_MONOTONIC_EN
    run_window("mono_6000", 16'sd6000, 16'sd0, 16'sd0, 16'sd0, 6000, 2, 0, 0, 0);
    run_window("ns_t1", 16'sd4000, 16'sd0, 16'sd0, 16'sd0, 4000, 2, 0, 0, 1);
`else
    run_window("mono_6000", 16'sd6000, 16'sd0, 16'sd0, 16'sd0, 6000, 6, 0, 0, 0);
    run_window("ns_t1", 16'sd4000, 16'sd0, 16'sd0, 16'sd0, 4000, 4, 0, 0, 1);
`endif
    run_window("after_ns_ref", 16'sd1000, 16'sd0, 16'sd0, 16'sd0, 1000, 8, 0, 0, 0);

    note_pulse();
    run_window("ref_zero", 16'sd0, 16'sd0, 16'sd0, 16'sd0, 0, 8, 0, 0, 0);
    run_window("ref0_w10", 16'sd10, 16'sd0, 16'sd0, 16'sd0, 10, 0, 0, 0, 0);

    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst2_silent", 32'(silent), 1);
    check("rst2_peak", 32'(peak), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
